// File: rtl/drc_axi_write_responder.sv
// Single-burst AXI write slave: accepts one AW burst, forwards valid beats to a
// registered memory write port, and returns OKAY/SLVERR with per-outcome counters.
module drc_axi_write_responder #(
  parameter int unsigned p_cnt_width = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            awaddr,
  input  logic [7:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic [3:0]             awcache,
  input  logic [2:0]             awproto,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [127:0]           wdata,
  input  logic [15:0]            wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic                   mem_full,
  output logic                   mem_wr,
  output logic [31:0]            mem_addr,
  output logic [127:0]           mem_data,
  output logic [15:0]            mem_strb,
  output logic [p_cnt_width-1:0] bursts_ok,
  output logic [p_cnt_width-1:0] bursts_err
);

  localparam int unsigned addr_w = 32;
  localparam int unsigned data_w = 128;
  localparam int unsigned strb_w = 16;
  localparam int unsigned len_w  = 8;
  localparam int unsigned span_w = 16;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                 state_q, state_d;
  logic                   awready_q, awready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [addr_w-1:0]      mem_addr_q, mem_addr_d;
  logic [data_w-1:0]      mem_data_q, mem_data_d;
  logic [strb_w-1:0]      mem_strb_q, mem_strb_d;
  logic [p_cnt_width-1:0] ok_q, ok_d;
  logic [p_cnt_width-1:0] err_cnt_q, err_cnt_d;
  logic [len_w-1:0]       cnt_q, cnt_d;
  logic [addr_w-1:0]      beat_addr_q, beat_addr_d;
  logic                   err_q, err_d;

  logic              aw_hs, w_hs, b_hs;
  logic              last_beat, beat_err, aw_err;
  logic [span_w-1:0] span_end;
  logic              unused_inputs;

  assign unused_inputs = ^{awcache, awproto};

  // W channel is throttled straight from the sink's full flag
  assign wready = (state_q == DATA) && !mem_full;

  assign aw_hs     = awvalid && awready_q;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid_q && bready;
  assign last_beat = (cnt_q == '0);
  assign beat_err  = err_q || (wlast != last_beat);
  // Offset within the 4 KB page plus burst byte length must not pass the page end
  assign span_end  = span_w'(awaddr[11:0]) + ((span_w'(awlen) + span_w'(1)) << 4);
  assign aw_err    = (awsize != 3'b100) || (awburst != 2'b01) || (span_end > span_w'(4096));

  always_comb begin
    state_d     = state_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_strb_d  = mem_strb_q;
    ok_d        = ok_q;
    err_cnt_d   = err_cnt_q;
    cnt_d       = cnt_q;
    beat_addr_d = beat_addr_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          beat_addr_d = {awaddr[31:4], 4'b0000};
          cnt_d       = awlen;
          err_d       = aw_err;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d       = beat_err;
          cnt_d       = cnt_q - len_w'(1);
          beat_addr_d = beat_addr_q + addr_w'(16);
          if (!beat_err) begin
            mem_wr_d   = 1'b1;
            mem_addr_d = beat_addr_q;
            mem_data_d = wdata;
            mem_strb_d = wstrb;
          end
          // Burst length is set by awlen alone; wlast only feeds the error check
          if (last_beat) begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = beat_err ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
          err_d    = 1'b0;
          if (err_q) err_cnt_d = err_cnt_q + p_cnt_width'(1);
          else       ok_d      = ok_q + p_cnt_width'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_strb_q  <= '0;
      ok_q        <= '0;
      err_cnt_q   <= '0;
      cnt_q       <= '0;
      beat_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_strb_q  <= mem_strb_d;
      ok_q        <= ok_d;
      err_cnt_q   <= err_cnt_d;
      cnt_q       <= cnt_d;
      beat_addr_q <= beat_addr_d;
      err_q       <= err_d;
    end
  end

  assign awready    = awready_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_strb   = mem_strb_q;
  assign bursts_ok  = ok_q;
  assign bursts_err = err_cnt_q;

endmodule

// File: tb/tb_drc_axi_write_responder.sv
// Scoreboard bench for drc_axi_write_responder: stimulus pushes expected writes
// and responses, a negedge monitor pops and compares them as the DUT emits them.
module tb_drc_axi_write_responder;

  localparam int unsigned cw = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [31:0]   awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic [3:0]    awcache = '0;
  logic [2:0]    awproto = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [127:0]  wdata = '0;
  logic [15:0]   wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic          mem_full = 1'b0;
  logic          mem_wr;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_data;
  logic [15:0]   mem_strb;
  logic [cw-1:0] bursts_ok;
  logic [cw-1:0] bursts_err;

  typedef struct packed {
    logic [31:0]  a;
    logic [127:0] d;
    logic [15:0]  s;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] bq[$];
  int         total = 0;
  int         bad = 0;

  drc_axi_write_responder #(.p_cnt_width(cw)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awproto(awproto), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_full(mem_full), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_strb(mem_strb),
    .bursts_ok(bursts_ok), .bursts_err(bursts_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'h1111_1111};
  endfunction

  // Monitor: pops scoreboard entries whenever the DUT writes or completes a B handshake
  always @(negedge i_clk) begin : monitor
    wr_t        e;
    logic [1:0] r;
    if (!i_rst) begin
      if (mem_wr) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_write_unexpected: got addr %0h want no write", mem_addr);
        end else begin
          e = wq.pop_front();
          check("mem_write", 176'({mem_addr, mem_data, mem_strb}), 176'(e));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got bresp %0h want no response", bresp);
        end else begin
          r = bq.pop_front();
          check("bresp", 176'(bresp), 176'(r));
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
    bit done;
    done = 0;
    @(negedge i_clk);
    awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (awready) begin
        @(posedge i_clk);
        #1 awvalid = 1'b0;
        done = 1;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL aw_timeout: got no awready want handshake");
      awvalid = 1'b0;
    end
  endtask

  task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic l,
                        input logic [31:0] a, input bit exp_wr);
    bit done;
    done = 0;
    @(negedge i_clk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (wready) begin
        if (exp_wr) wq.push_back({a, d, s});
        @(posedge i_clk);
        #1 wvalid = 1'b0;
        done = 1;
      end else begin
        @(negedge i_clk);
        #1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL w_timeout: got no wready want handshake");
      wvalid = 1'b0;
    end
  endtask

  task automatic wait_b();
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge i_clk);
      if (bvalid && bready) begin
        @(posedge i_clk);
        #1 done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL b_timeout: got no B handshake want handshake");
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset values, asserted asynchronously before any clock edge
    #2 i_rst = 1'b1;
    #1;
    check("rst_awready", 176'(awready), 176'(0));
    check("rst_bvalid", 176'(bvalid), 176'(0));
    check("rst_mem_wr", 176'(mem_wr), 176'(0));
    check("rst_mem_addr", 176'(mem_addr), 176'(0));
    check("rst_counters", 176'({bursts_ok, bursts_err}), 176'(0));
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1 check("awready_before_edge", 176'(awready), 176'(0));
    @(negedge i_clk);
    check("awready_after_rst", 176'(awready), 176'(1));

    // Aligned 4-beat INCR burst
    bq.push_back(2'b00);
    send_aw(32'h0000_1000, 8'd3, 3'b100, 2'b01);
    for (int i = 0; i < 4; i++)
      send_w(pat(i), 16'hFFFF, i == 3, 32'h1000 + 32'(16 * i), 1'b1);
    wait_b();
    check("ok_after_basic", 176'(bursts_ok), 176'(1));

    // 4 KB crossing: beats swallowed, SLVERR
    bq.push_back(2'b10);
    send_aw(32'h0000_0FF0, 8'd1, 3'b100, 2'b01);
    send_w(pat(10), 16'hFFFF, 1'b0, 32'h0, 1'b0);
    send_w(pat(11), 16'hFFFF, 1'b1, 32'h0, 1'b0);
    wait_b();
    check("err_after_4k", 176'(bursts_err), 176'(1));

    // Early wlast on beat 2: beats 0,1 written, 2,3 discarded, burst still 4 beats
    bq.push_back(2'b10);
    send_aw(32'h0000_2040, 8'd3, 3'b100, 2'b01);
    send_w(pat(20), 16'h00FF, 1'b0, 32'h2040, 1'b1);
    send_w(pat(21), 16'hFF00, 1'b0, 32'h2050, 1'b1);
    send_w(pat(22), 16'hFFFF, 1'b1, 32'h0, 1'b0);
    send_w(pat(23), 16'hFFFF, 1'b0, 32'h0, 1'b0);
    wait_b();
    check("err_after_wlast", 176'(bursts_err), 176'(2));
    check("ok_unchanged", 176'(bursts_ok), 176'(1));

    // Sink back-pressure on beat 1; unaligned start address rounds down
    bq.push_back(2'b00);
    send_aw(32'h0000_3008, 8'd1, 3'b100, 2'b01);
    send_w(pat(30), 16'h0F0F, 1'b0, 32'h3000, 1'b1);
    fork
      send_w(pat(31), 16'hF0F0, 1'b1, 32'h3010, 1'b1);
      begin
        mem_full = 1'b1;
        repeat (5) begin
          @(negedge i_clk);
          #1 check("wready_stall", 176'(wready), 176'(0));
        end
        @(posedge i_clk);
        #2 mem_full = 1'b0;
      end
    join
    wait_b();
    check("ok_after_stall", 176'(bursts_ok), 176'(2));

    // B back-pressure: response held stable, no new AW accepted
    bready = 1'b0;
    bq.push_back(2'b00);
    send_aw(32'h0000_4000, 8'd0, 3'b100, 2'b01);
    send_w(pat(40), 16'hFFFF, 1'b1, 32'h4000, 1'b1);
    for (int i = 0; i < 50 && !bvalid; i++) @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("bhold_bvalid", 176'(bvalid), 176'(1));
      check("bhold_bresp", 176'(bresp), 176'(0));
      check("bhold_awready", 176'(awready), 176'(0));
    end
    @(posedge i_clk);
    #1 bready = 1'b1;
    wait_b();
    check("awready_after_b", 176'(awready), 176'(1));
    check("bvalid_after_b", 176'(bvalid), 176'(0));
    check("ok_after_bhold", 176'(bursts_ok), 176'(3));

    // Reset mid-burst after 2 of 4 beats: burst abandoned, no response
    send_aw(32'h0000_5000, 8'd3, 3'b100, 2'b01);
    send_w(pat(50), 16'hFFFF, 1'b0, 32'h5000, 1'b1);
    send_w(pat(51), 16'hFFFF, 1'b0, 32'h5010, 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);
    #1 check("wready_mid_burst", 176'(wready), 176'(1));
    i_rst = 1'b1;
    #1;
    check("mrst_wready", 176'(wready), 176'(0));
    check("mrst_awready", 176'(awready), 176'(0));
    check("mrst_b", 176'({bvalid, bresp}), 176'(0));
    check("mrst_mem", 176'({mem_wr, mem_addr, mem_data, mem_strb}), 176'(0));
    check("mrst_counters", 176'({bursts_ok, bursts_err}), 176'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    bq.push_back(2'b00);
    send_aw(32'h0000_6000, 8'd1, 3'b100, 2'b01);
    send_w(pat(60), 16'hFFFF, 1'b0, 32'h6000, 1'b1);
    send_w(pat(61), 16'hFFFF, 1'b1, 32'h6010, 1'b1);
    wait_b();
    check("ok_after_rst", 176'(bursts_ok), 176'(1));
    check("err_after_rst", 176'(bursts_err), 176'(0));

    repeat (3) @(negedge i_clk);
    check("wq_drained", 176'(wq.size()), 176'(0));
    check("bq_drained", 176'(bq.size()), 176'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
